sigmoid_sequencer: RTL and testbench

Initiator-side controller for the 32-entry sigmoid activation unit. On `start`, it walks a vector of up to 32 fixed-point (1.7.24) values held in a synchronous-read buffer. It issues each value with its index to the activation unit and waits for the unit's valid pulse, then writes the returned result into a result buffer at the returned address. It sits between the layer-output buffer and the next layer's input buffer, and reports completion, timeout and address-mismatch status.

---
 rtl/sigmoid_sequencer.sv | 158 +++++++++++++++
 tb/tb_sigmoid_sequencer.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_sequencer.sv
// Initiator-side controller for the sigmoid activation unit: reads a vector
// from the source buffer, issues each element, and writes results back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; latches clamped length
// S_READ  | source buffer read strobe for element idx
// S_LOAD  | capture read data and index into the operand registers
// S_ISSUE | one-cycle request pulse to the activation unit
// S_WAIT  | wait for result valid, bounded by the timeout down-counter
// S_WRITE | write captured result to the result buffer
// S_DONE  | one-cycle completion pulse

module sigmoid_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   vec_len,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              act_en,
    output logic [DATA_W-1:0] act_data,
    output logic [ADDR_W-1:0] act_addr,
    input  logic [DATA_W-1:0] act_out_data,
    input  logic [ADDR_W-1:0] act_out_addr,
    input  logic              act_out_valid,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [DATA_W-1:0] res_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int              MAX_LEN_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN   = MAX_LEN_I[ADDR_W:0];
    localparam logic [7:0]      TMR_LOAD  = 8'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        tmr;
    logic [ADDR_W:0]   len_clamped;

    always_comb begin
        len_clamped = vec_len;
        if (vec_len > MAX_LEN) len_clamped = MAX_LEN;
    end

    // idx only changes on the WRITE->READ transition, so it is stable in READ
    assign buf_rd_addr = idx;

    // Strobes are assigned on the transition into their state so that they are
    // registered and high exactly for the one cycle spent in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len         <= '0;
            idx         <= '0;
            tmr         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 2'b00;
            buf_rd_en   <= 1'b0;
            act_en      <= 1'b0;
            act_data    <= '0;
            act_addr    <= '0;
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
        end else begin
            buf_rd_en <= 1'b0;
            act_en    <= 1'b0;
            res_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len  <= len_clamped;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (len_clamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            error     <= 2'b00;
                            state     <= S_READ;
                            buf_rd_en <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    act_data <= buf_rd_data;
                    act_addr <= idx;
                    act_en   <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    tmr   <= TMR_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // a valid in the last allowed cycle still wins over the abort
                    if (act_out_valid) begin
                        res_wr_addr <= act_out_addr;
                        res_wr_data <= act_out_data;
                        if (act_out_addr != act_addr) error[1] <= 1'b1;
                        res_wr_en   <= 1'b1;
                        state       <= S_WRITE;
                    end else if (tmr == 8'd0) begin
                        error[0] <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_WRITE: begin
                    if ({1'b0, idx} == len - 1'b1) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx       <= idx + 1'b1;
                        buf_rd_en <= 1'b1;
                        state     <= S_READ;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_sequencer.sv
// Self-checking bench for sigmoid_sequencer: buffer and activation-unit models
// driven on the falling edge, results compared against a sequence-level model.

module tb_sigmoid_sequencer;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   vec_len = '0;
    logic              busy, done, buf_rd_en, act_en, res_wr_en;
    logic [1:0]        error;
    logic [ADDR_W-1:0] buf_rd_addr, act_addr, res_wr_addr;
    logic [DATA_W-1:0] act_data, res_wr_data;
    logic [DATA_W-1:0] buf_rd_data = '0;
    logic [DATA_W-1:0] act_out_data = '0;
    logic [ADDR_W-1:0] act_out_addr = '0;
    logic              act_out_valid = 1'b0;

    always #5 clk = ~clk;

    sigmoid_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .error(error),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .act_en(act_en), .act_data(act_data), .act_addr(act_addr),
        .act_out_data(act_out_data), .act_out_addr(act_out_addr), .act_out_valid(act_out_valid),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // environment knobs
    logic [DATA_W-1:0] mem [32];
    int lat [32];
    int timeout_elem = -1;
    int mism_elem = -1;
    int stray_elem = -1;
    int cyc = 0;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } resp_t;
    resp_t pend[$];
    bit rd_pend = 0;
    logic [ADDR_W-1:0] rd_addr_q = '0;

    // monitor records
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int rd_cnt = 0, done_cnt = 0, done_cyc = -1, start_cyc = 0;
    int hold_viol = 0, busy_viol = 0;
    logic [DATA_W-1:0] held_data = '0;
    logic [ADDR_W-1:0] held_addr = '0;
    bit waiting = 0, real_valid = 0, done_prev = 0;

    // reference expectations
    logic [ADDR_W-1:0] exp_wa[$];
    logic [DATA_W-1:0] exp_wd[$];
    logic [1:0] exp_err = 2'b00;
    int exp_lat = 0, exp_rd = 0;

    function automatic logic [DATA_W-1:0] sig_f(input logic [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] s;
        s = $signed(x) >>> 2;
        return s + 32'h0080_0000;
    endfunction

    // Sequence-level model: which elements get written where, sticky error, cycle count
    function automatic void ref_model(input int vlen);
        int n, a;
        n = (vlen > 32) ? 32 : vlen;
        exp_wa.delete();
        exp_wd.delete();
        if (n > 0) exp_err = 2'b00;
        exp_lat = 1;
        exp_rd = 0;
        for (int i = 0; i < n; i++) begin
            exp_rd++;
            if (i == timeout_elem) begin
                exp_err[0] = 1'b1;
                exp_lat += 3 + TIMEOUT;
                break;
            end
            exp_lat += 4 + lat[i];
            a = (i == mism_elem) ? (i + 1) % 32 : i;
            if (a != i) exp_err[1] = 1'b1;
            exp_wa.push_back(ADDR_W'(a));
            exp_wd.push_back(sig_f(mem[i]));
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Buffer / activation unit models and output monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend.delete();
            act_out_valid = 1'b0;
            rd_pend = 0;
            waiting = 0;
            real_valid = 0;
            continue;
        end
        if (buf_rd_en) rd_cnt++;
        if (res_wr_en) begin
            wr_addr_q.push_back(res_wr_addr);
            wr_data_q.push_back(res_wr_data);
        end
        if (done_prev && busy) busy_viol++;
        if (done && !busy) busy_viol++;
        done_prev = done;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (waiting && (act_data !== held_data || act_addr !== held_addr)) hold_viol++;
        if (act_out_valid && real_valid) waiting = 0;
        if (act_en) begin
            held_data = act_data;
            held_addr = act_addr;
            waiting = 1;
        end

        act_out_valid = 1'b0;
        real_valid = 0;
        buf_rd_data = rd_pend ? mem[rd_addr_q] : $urandom;
        rd_pend = buf_rd_en;
        rd_addr_q = buf_rd_addr;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            act_out_valid = 1'b1;
            act_out_data = pend[0].data;
            act_out_addr = pend[0].addr;
            real_valid = 1;
            void'(pend.pop_front());
        end else if (buf_rd_en && int'(buf_rd_addr) == stray_elem) begin
            act_out_valid = 1'b1;
            act_out_data = $urandom;
            act_out_addr = ~buf_rd_addr;
        end
        if (act_en && int'(act_addr) != timeout_elem)
            pend.push_back('{cyc + lat[act_addr], sig_f(act_data),
                             (int'(act_addr) == mism_elem) ? act_addr + 1'b1 : act_addr});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_env(input bit ramp, input int t_el, input int m_el, input int s_el, input bit rnd_lat);
        for (int i = 0; i < 32; i++) begin
            mem[i] = ramp ? 32'(i) * 32'h0010_0000 : $urandom;
            lat[i] = rnd_lat ? int'($urandom_range(1, 8)) : 4;
        end
        timeout_elem = t_el;
        mism_elem = m_el;
        stray_elem = s_el;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        hold_viol = 0;
        busy_viol = 0;
    endtask

    task automatic run_seq(input int vlen, input int interfere_at);
        int r;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        vec_len = vlen[ADDR_W:0];
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        r = $urandom;
        vec_len = r[ADDR_W:0];
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise len=%0d: got %b want 1", vlen, busy);
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(negedge clk);
            start = (i == interfere_at);
            if (i == interfere_at) vec_len = 3;
        end
        start = 1'b0;
        n_cmp++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL done_wait len=%0d: got no done want done", vlen);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, error, buf_rd_en, buf_rd_addr, act_en, act_data, act_addr,
             res_wr_en, res_wr_addr, res_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b act_en=%b wr=%b want all 0",
                     busy, done, error, buf_rd_en, act_en, res_wr_en);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b dones=%0d want 0/0", busy, done_cnt);
        end
    endtask

    task automatic test_full_vector();
        set_env(1, -1, -1, -1, 0);
        run_seq(32, -1);
        ref_model(32);
        n_cmp++;
        if (done_cyc - start_cyc != 257 || exp_lat != 257) begin
            n_fail++;
            $display("FAIL full_latency: got %0d want 257", done_cyc - start_cyc);
        end
        n_cmp++;
        if (wr_addr_q.size() != exp_wa.size()) begin
            n_fail++;
            $display("FAIL full_wr_count: got %0d want %0d", wr_addr_q.size(), exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL full_write[%0d]: got %0d/%h want %0d/%h", i,
                         wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        n_cmp++;
        if (error !== exp_err || rd_cnt != exp_rd || done_cnt != 1 || hold_viol != 0 || busy_viol != 0) begin
            n_fail++;
            $display("FAIL full_status: got err=%b rd=%0d dones=%0d hold=%0d busy=%0d want err=%b rd=%0d 1 0 0",
                     error, rd_cnt, done_cnt, hold_viol, busy_viol, exp_err, exp_rd);
        end
    endtask

    task automatic test_zero_and_clamp();
        int lens[2];
        lens = '{0, 40};
        foreach (lens[k]) begin
            set_env(0, -1, -1, -1, 0);
            run_seq(lens[k], -1);
            ref_model(lens[k]);
            n_cmp++;
            if (done_cyc - start_cyc != exp_lat) begin
                n_fail++;
                $display("FAIL zc_latency len=%0d: got %0d want %0d", lens[k], done_cyc - start_cyc, exp_lat);
            end
            n_cmp++;
            if (wr_addr_q.size() != exp_wa.size() || rd_cnt != exp_rd) begin
                n_fail++;
                $display("FAIL zc_counts len=%0d: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                         lens[k], wr_addr_q.size(), rd_cnt, exp_wa.size(), exp_rd);
            end
            for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
                n_cmp++;
                if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                    n_fail++;
                    $display("FAIL zc_write[%0d]: got %0d/%h want %0d/%h", i,
                             wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
                end
            end
            n_cmp++;
            if (error !== exp_err || done_cnt != 1 || busy_viol != 0) begin
                n_fail++;
                $display("FAIL zc_status len=%0d: got err=%b dones=%0d busy=%0d want err=%b 1 0",
                         lens[k], error, done_cnt, busy_viol, exp_err);
            end
        end
    endtask

    task automatic test_timeout();
        set_env(0, 3, -1, -1, 0);
        run_seq(16, -1);
        ref_model(16);
        n_cmp++;
        if (done_cyc - start_cyc != exp_lat) begin
            n_fail++;
            $display("FAIL to_latency: got %0d want %0d", done_cyc - start_cyc, exp_lat);
        end
        n_cmp++;
        if (wr_addr_q.size() != exp_wa.size() || rd_cnt != exp_rd) begin
            n_fail++;
            $display("FAIL to_counts: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                     wr_addr_q.size(), rd_cnt, exp_wa.size(), exp_rd);
        end
        for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL to_write[%0d]: got %0d/%h want %0d/%h", i,
                         wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        n_cmp++;
        if (error !== 2'b01 || exp_err !== 2'b01 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL to_error: got err=%b dones=%0d want 01 1", error, done_cnt);
        end
    endtask

    task automatic test_mismatch();
        set_env(0, -1, 5, -1, 0);
        run_seq(12, -1);
        ref_model(12);
        n_cmp++;
        if (done_cyc - start_cyc != exp_lat || wr_addr_q.size() != exp_wa.size()) begin
            n_fail++;
            $display("FAIL mm_shape: got lat=%0d wr=%0d want lat=%0d wr=%0d",
                     done_cyc - start_cyc, wr_addr_q.size(), exp_lat, exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL mm_write[%0d]: got %0d/%h want %0d/%h", i,
                         wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        n_cmp++;
        if (error !== 2'b10 || exp_err !== 2'b10) begin
            n_fail++;
            $display("FAIL mm_error: got %b want 10", error);
        end
    endtask

    task automatic test_interference();
        set_env(0, -1, -1, 2, 0);
        run_seq(12, 20);
        ref_model(12);
        stray_elem = -1;
        n_cmp++;
        if (done_cyc - start_cyc != exp_lat || wr_addr_q.size() != exp_wa.size() || done_cnt != 1) begin
            n_fail++;
            $display("FAIL intf_shape: got lat=%0d wr=%0d dones=%0d want lat=%0d wr=%0d 1",
                     done_cyc - start_cyc, wr_addr_q.size(), done_cnt, exp_lat, exp_wa.size());
        end
        for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL intf_write[%0d]: got %0d/%h want %0d/%h", i,
                         wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        n_cmp++;
        if (hold_viol != 0 || error !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL intf_status: got hold=%0d err=%b busy=%b want 0 %b 0", hold_viol, error, busy, exp_err);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int vlen, me;
            vlen = $urandom_range(0, 63);
            me = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
            set_env(0, -1, me, -1, 1);
            run_seq(vlen, -1);
            ref_model(vlen);
            n_cmp++;
            if (done_cyc - start_cyc != exp_lat || wr_addr_q.size() != exp_wa.size() || rd_cnt != exp_rd) begin
                n_fail++;
                $display("FAIL rnd_shape it=%0d len=%0d: got lat=%0d wr=%0d rd=%0d want lat=%0d wr=%0d rd=%0d",
                         it, vlen, done_cyc - start_cyc, wr_addr_q.size(), rd_cnt, exp_lat, exp_wa.size(), exp_rd);
            end
            for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
                n_cmp++;
                if (wr_addr_q[i] !== exp_wa[i] || wr_data_q[i] !== exp_wd[i]) begin
                    n_fail++;
                    $display("FAIL rnd_write it=%0d [%0d]: got %0d/%h want %0d/%h", it, i,
                             wr_addr_q[i], wr_data_q[i], exp_wa[i], exp_wd[i]);
                end
            end
            n_cmp++;
            if (error !== exp_err || hold_viol != 0 || busy_viol != 0) begin
                n_fail++;
                $display("FAIL rnd_status it=%0d: got err=%b hold=%0d busy=%0d want err=%b 0 0",
                         it, error, hold_viol, busy_viol, exp_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        int i;
        set_env(0, -1, -1, -1, 0);
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        vec_len = 32;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (!(act_en === 1'b1 && act_addr === 5'd10) && i < 500) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (i >= 500) begin
            n_fail++;
            $display("FAIL rstmid_reach: got no issue of element 10 want issue");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, error, buf_rd_en, buf_rd_addr, act_en, act_data, act_addr,
             res_wr_en, res_wr_addr, res_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got busy=%b act_en=%b act_addr=%0d act_data=%h want all 0",
                     busy, act_en, act_addr, act_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || wr_addr_q.size() != 10 || done_cnt != 0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got busy=%b wr=%0d dones=%0d want 0 10 0", busy, wr_addr_q.size(), done_cnt);
        end
        run_seq(4, -1);
        ref_model(4);
        n_cmp++;
        if (done_cyc - start_cyc != exp_lat || wr_addr_q.size() != exp_wa.size() || error !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_rerun: got lat=%0d wr=%0d err=%b want lat=%0d wr=%0d err=00",
                     done_cyc - start_cyc, wr_addr_q.size(), error, exp_lat, exp_wa.size());
        end
        for (int k = 0; k < exp_wa.size() && k < wr_addr_q.size(); k++) begin
            n_cmp++;
            if (wr_addr_q[k] !== exp_wa[k] || wr_data_q[k] !== exp_wd[k]) begin
                n_fail++;
                $display("FAIL rstmid_write[%0d]: got %0d/%h want %0d/%h", k,
                         wr_addr_q[k], wr_data_q[k], exp_wa[k], exp_wd[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            lat[i] = 4;
        end
        test_reset();
        test_zero_and_clamp();
        test_full_vector();
        test_timeout();
        test_mismatch();
        test_interference();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
